bus_slave_mux: RTL



---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_wdog.sv | 37 +++
 rtl/bus_slave_mux.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the processing-domain fan-out stage:
// bus widths, FSM state type and the slot-decode helper.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  // Read data returned on unmapped or timed-out accesses.
  localparam logic [BUS_DW-1:0] TO_RDATA = 32'h0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic [BUS_AW-1:0] idx_of(input logic [BUS_AW-1:0] addr,
                                               input int slv_aw,
                                               input int dec_w);
    logic [BUS_AW-1:0] mask;
    mask = (BUS_AW'(1) << dec_w) - BUS_AW'(1);
    return (addr >> slv_aw) & mask;
  endfunction

endpackage

// File: rtl/bus_wdog.sv
// Watchdog counter for an outstanding slave access: cleared at launch,
// advanced once per waiting cycle, expire_o flags the final allowed cycle.
module bus_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_slave_mux.sv
// System-bus fan-out: decodes a slot from the address, strobes one slave,
// waits for its ack (bounded by a watchdog) and returns a registered completion.
module bus_slave_mux
  import bus_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 20,
  parameter int DEC_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BUS_AW-1:0]         addr_i,
  input  logic [BUS_DW-1:0]         wdata_i,
  input  logic                      wen_i,
  input  logic                      ren_i,
  output logic [BUS_DW-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      ack_o,
  output logic [BUS_AW-1:0]         slv_addr_o,
  output logic [BUS_DW-1:0]         slv_wdata_o,
  output logic [NUM_SLV-1:0]        slv_wen_o,
  output logic [NUM_SLV-1:0]        slv_ren_o,
  input  logic [BUS_DW*NUM_SLV-1:0] slv_rdata_i,
  input  logic [NUM_SLV-1:0]        slv_err_i,
  input  logic [NUM_SLV-1:0]        slv_ack_i,
  output logic                      drop_o
);

  localparam int SLOT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   idx_q, idx_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                drop_q, drop_d;
  logic [BUS_DW-1:0]   rdata_q, rdata_d;
  logic [BUS_AW-1:0]   saddr_q, saddr_d;
  logic [BUS_DW-1:0]   swdata_q, swdata_d;
  logic [NUM_SLV-1:0]  swen_q, swen_d;
  logic [NUM_SLV-1:0]  sren_q, sren_d;

  logic [BUS_AW-1:0]   dec_idx;
  logic                mapped;
  logic [SLOT_W-1:0]   slot;
  logic                req;
  logic                sel_ack, sel_err;
  logic [BUS_DW-1:0]   sel_rdata;
  logic                wd_clr, wd_en, wd_expire;

  assign dec_idx = idx_of(addr_i, SLV_AW, DEC_W);
  assign mapped  = (dec_idx < BUS_AW'(NUM_SLV));
  assign slot    = dec_idx[SLOT_W-1:0];
  assign req     = wen_i | ren_i;

  // Only the latched slot is observed; other slots' responses never reach the FSM.
  always_comb begin
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx_q == SLOT_W'(k)) begin
        sel_ack   = slv_ack_i[k];
        sel_err   = slv_err_i[k];
        sel_rdata = slv_rdata_i[k*BUS_DW +: BUS_DW];
      end
    end
  end

  bus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    drop_d   = drop_q;
    rdata_d  = rdata_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    swen_d   = '0;
    sren_d   = '0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (ack_q) begin
            // A request during the completion cycle cannot be serviced.
            drop_d = 1'b1;
          end else if (!mapped) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = TO_RDATA;
          end else begin
            saddr_d  = addr_i;
            swdata_d = wdata_i;
            if (wen_i) swen_d[slot] = 1'b1;
            else       sren_d[slot] = 1'b1;
            idx_d   = slot;
            wd_clr  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (req) drop_d = 1'b1;
        if (sel_ack) begin
          ack_d   = 1'b1;
          err_d   = sel_err;
          rdata_d = sel_rdata;
          state_d = IDLE;
        end else if (wd_expire) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = TO_RDATA;
          state_d = IDLE;
        end else begin
          wd_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      rdata_q  <= '0;
      saddr_q  <= '0;
      swdata_q <= '0;
      swen_q   <= '0;
      sren_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      rdata_q  <= rdata_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      swen_q   <= swen_d;
      sren_q   <= sren_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign ack_o       = ack_q;
  assign slv_addr_o  = saddr_q;
  assign slv_wdata_o = swdata_q;
  assign slv_wen_o   = swen_q;
  assign slv_ren_o   = sren_q;
  assign drop_o      = drop_q;

endmodule
